// File: rtl/lut_accumulator.sv
// lut_accumulator: per-lane signed LUT lookup with saturating accumulate, result held until accepted
// clk, rst_n_i      : rising-edge clock, async active-low reset
// lut_entries_i     : 16 signed 16b entries, entry k at [16k+15:16k]
// w_code_i          : per-lane {neg, idx[3:0]}, lane n at [5n+4:5n]
// in_valid_i/in_last_i/in_ready_o : beat handshake, in_last_i closes a group
// clear_i           : sync abort of group, result and code_err_o
// result_o/beat_cnt_o/out_valid_o/out_ready_i : held group result handshake
// code_err_o        : sticky, idx 14/15 seen since reset or clear
module lut_accumulator #(
  parameter int NUM_LANES = 4,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n_i,
  input  logic [255:0]               lut_entries_i,
  input  logic [5*NUM_LANES-1:0]     w_code_i,
  input  logic                       in_valid_i,
  input  logic                       in_last_i,
  output logic                       in_ready_o,
  input  logic                       clear_i,
  output logic [ACC_W*NUM_LANES-1:0] result_o,
  output logic [CNT_W-1:0]           beat_cnt_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       code_err_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state_q, state_d;
  logic ready_q;
  logic [ACC_W*NUM_LANES-1:0] acc_q, acc_d, acc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic code_err_q, code_err_d;
  logic [NUM_LANES-1:0] bad;
  logic beat;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [3:0] idx;
    logic signed [15:0] ent;
    logic signed [16:0] term;
    logic signed [ACC_W:0] sum;
    assign idx = w_code_i[5*l +: 4];
    assign ent = lut_entries_i[16*idx +: 16];
    assign bad[l] = &idx[3:1];
    // 17 bits so that negating -32768 is exact
    assign term = bad[l] ? 17'sd0 : w_code_i[5*l+4] ? -17'(ent) : 17'(ent);
    // a beat in IDLE starts a fresh group, so the stale accumulator is ignored
    assign sum = $signed(state_q == IDLE ? '0 : acc_q[ACC_W*l +: ACC_W]) + term;
    // overflow when the top two bits disagree; clamp toward the sign of the true sum
    assign acc_nxt[ACC_W*l +: ACC_W] = (sum[ACC_W] != sum[ACC_W-1]) ?
      {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
  end
  // ready_q keeps in_ready_o low during reset and for the first cycle after release
  assign in_ready_o = ready_q & (state_q != DONE);
  assign beat = in_valid_i & in_ready_o;
  assign out_valid_o = state_q == DONE;
  assign result_o = acc_q;
  assign beat_cnt_o = cnt_q;
  assign code_err_o = code_err_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    code_err_d = code_err_q;
    if (beat) begin
      state_d = in_last_i ? DONE : ACCUM;
      acc_d = acc_nxt;
      cnt_d = (state_q == IDLE) ? CNT_W'(1) : (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      code_err_d = code_err_q | (|bad);
    end
    if (out_valid_o && out_ready_i) state_d = IDLE;
    if (clear_i) begin
      state_d = IDLE;
      acc_d = '0;
      cnt_d = '0;
      code_err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      code_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      code_err_q <= code_err_d;
    end
  end
endmodule

// File: tb/tb_lut_accumulator.sv
// tb_lut_accumulator: directed checks of lut_accumulator at ACC_W=24 and ACC_W=17
module tb_lut_accumulator;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [255:0] lut = '0;
  logic [19:0] codes = '0;
  logic in_ready, out_valid, err, in_ready17, out_valid17, err17;
  logic [95:0] res;
  logic [67:0] res17;
  logic [7:0] cnt, cnt17;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  lut_accumulator dut (
    .clk(clk), .rst_n_i(rst_n), .lut_entries_i(lut), .w_code_i(codes),
    .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready), .clear_i(clear),
    .result_o(res), .beat_cnt_o(cnt), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .code_err_o(err)
  );
  lut_accumulator #(.ACC_W(17)) dut17 (
    .clk(clk), .rst_n_i(rst_n), .lut_entries_i(lut), .w_code_i(codes),
    .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready17), .clear_i(clear),
    .result_o(res17), .beat_cnt_o(cnt17), .out_valid_o(out_valid17), .out_ready_i(out_ready),
    .code_err_o(err17)
  );
  function automatic logic [19:0] all4(input logic [4:0] c);
    return {4{c}};
  endfunction
  task automatic beat(input logic [19:0] c, input logic last);
    codes = c; in_valid = 1'b1; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (res !== 96'd0) begin n_bad++; $display("FAIL rst_result got %h want 0", res); end
    n_cmp++; if (cnt !== 8'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
    #6 rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_release_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after got %b want 1", in_ready); end
  endtask
  task automatic test_basic;
    lut[16*0 +: 16] = 16'd7;
    lut[16*3 +: 16] = -16'sd5;
    lut[16*9 +: 16] = 16'd100;
    lut[16*13 +: 16] = 16'd300;
    beat({5'h00, 5'h1D, 5'h03, 5'h09}, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_b1 got %b want 0", out_valid); end
    n_cmp++; if (res[23:0] !== 24'd100) begin n_bad++; $display("FAIL basic_lane0_b1 got %h want %h", res[23:0], 24'd100); end
    beat({5'h00, 5'h1D, 5'h03, 5'h0D}, 1'b0);
    beat({5'h00, 5'h1D, 5'h03, 5'h19}, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready got %b want 0", in_ready); end
    n_cmp++; if (cnt !== 8'd3) begin n_bad++; $display("FAIL basic_cnt got %0d want 3", cnt); end
    n_cmp++; if (res !== {24'sd21, -24'sd900, -24'sd15, 24'sd300}) begin n_bad++; $display("FAIL basic_result got %h want %h", res, {24'sd21, -24'sd900, -24'sd15, 24'sd300}); end
    release_out;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drop got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_idle got %b want 1", in_ready); end
  endtask
  task automatic test_neg_min;
    lut[16*5 +: 16] = 16'h8000;
    beat({5'h10, 5'h00, 5'h05, 5'h15}, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL negmin_valid got %b want 1", out_valid); end
    n_cmp++; if (cnt !== 8'd1) begin n_bad++; $display("FAIL negmin_cnt got %0d want 1", cnt); end
    n_cmp++; if (res !== {-24'sd7, 24'sd7, -24'sd32768, 24'sd32768}) begin n_bad++; $display("FAIL negmin_result got %h want %h", res, {-24'sd7, 24'sd7, -24'sd32768, 24'sd32768}); end
    n_cmp++; if (res17 !== {-17'sd7, 17'sd7, -17'sd32768, 17'sd32768}) begin n_bad++; $display("FAIL negmin_result17 got %h want %h", res17, {-17'sd7, 17'sd7, -17'sd32768, 17'sd32768}); end
    release_out;
  endtask
  task automatic test_saturation;
    lut[16*12 +: 16] = 16'h7FFF;
    for (int i = 0; i < 3; i++) beat({5'h00, 5'h00, 5'h1C, 5'h0C}, 1'b0);
    n_cmp++; if (res17[16:0] !== 17'sd65535) begin n_bad++; $display("FAIL sat17_b3 got %h want %h", res17[16:0], 17'sd65535); end
    beat({5'h00, 5'h00, 5'h1C, 5'h0C}, 1'b1);
    n_cmp++; if (res !== {24'sd28, 24'sd28, -24'sd131068, 24'sd131068}) begin n_bad++; $display("FAIL sat24_result got %h want %h", res, {24'sd28, 24'sd28, -24'sd131068, 24'sd131068}); end
    n_cmp++; if (res17 !== {17'sd28, 17'sd28, 17'h10000, 17'sd65535}) begin n_bad++; $display("FAIL sat17_result got %h want %h", res17, {17'sd28, 17'sd28, 17'h10000, 17'sd65535}); end
    n_cmp++; if (cnt17 !== 8'd4) begin n_bad++; $display("FAIL sat17_cnt got %0d want 4", cnt17); end
    release_out;
  endtask
  task automatic test_cnt_sat;
    lut[16*1 +: 16] = 16'd1;
    for (int i = 0; i < 299; i++) beat(all4(5'h01), 1'b0);
    beat(all4(5'h01), 1'b1);
    n_cmp++; if (cnt !== 8'd255) begin n_bad++; $display("FAIL cntsat_cnt got %0d want 255", cnt); end
    n_cmp++; if (res !== {4{24'sd300}}) begin n_bad++; $display("FAIL cntsat_result got %h want %h", res, {4{24'sd300}}); end
    release_out;
  endtask
  task automatic test_hold;
    beat(all4(5'h09), 1'b0);
    beat(all4(5'h09), 1'b1);
    for (int i = 0; i < 5; i++) begin
      codes = all4(5'h0D); in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (res !== {4{24'sd200}}) begin n_bad++; $display("FAIL hold_result[%0d] got %h want %h", i, res, {4{24'sd200}}); end
      n_cmp++; if ({out_valid, in_ready, cnt} !== {1'b1, 1'b0, 8'd2}) begin n_bad++; $display("FAIL hold_ctrl[%0d] got %b/%b/%0d want 1/0/2", i, out_valid, in_ready, cnt); end
    end
    in_valid = 1'b0;
    release_out;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_drop got %b want 0", out_valid); end
    beat(all4(5'h0D), 1'b1);
    n_cmp++; if (res !== {4{24'sd300}}) begin n_bad++; $display("FAIL hold_next got %h want %h", res, {4{24'sd300}}); end
    n_cmp++; if (cnt !== 8'd1) begin n_bad++; $display("FAIL hold_next_cnt got %0d want 1", cnt); end
    release_out;
  endtask
  task automatic test_code_err;
    lut[16*14 +: 16] = 16'h1234;
    lut[16*15 +: 16] = 16'h4321;
    beat({5'h01, 5'h01, 5'h1F, 5'h0E}, 1'b1);
    n_cmp++; if (res !== {24'sd1, 24'sd1, 24'sd0, 24'sd0}) begin n_bad++; $display("FAIL err_result got %h want %h", res, {24'sd1, 24'sd1, 24'sd0, 24'sd0}); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", err); end
    release_out;
    beat(all4(5'h01), 1'b1);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err); end
    release_out;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err); end
  endtask
  task automatic test_clear;
    beat(all4(5'h01), 1'b0);
    beat(all4(5'h01), 1'b0);
    n_cmp++; if (cnt !== 8'd2) begin n_bad++; $display("FAIL clr_pre_cnt got %0d want 2", cnt); end
    codes = all4(5'h09); in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    n_cmp++; if ({out_valid, in_ready, cnt} !== {1'b0, 1'b1, 8'd0}) begin n_bad++; $display("FAIL clr_mid_ctrl got %b/%b/%0d want 0/1/0", out_valid, in_ready, cnt); end
    n_cmp++; if (res !== 96'd0) begin n_bad++; $display("FAIL clr_mid_result got %h want 0", res); end
    beat(all4(5'h09), 1'b1);
    n_cmp++; if (res !== {4{24'sd100}}) begin n_bad++; $display("FAIL clr_next got %h want %h", res, {4{24'sd100}}); end
    n_cmp++; if (cnt !== 8'd1) begin n_bad++; $display("FAIL clr_next_cnt got %0d want 1", cnt); end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_cmp++; if ({out_valid, in_ready, cnt} !== {1'b0, 1'b1, 8'd0}) begin n_bad++; $display("FAIL clr_done_ctrl got %b/%b/%0d want 0/1/0", out_valid, in_ready, cnt); end
    n_cmp++; if (res !== 96'd0) begin n_bad++; $display("FAIL clr_done_result got %h want 0", res); end
  endtask
  task automatic test_async_reset;
    beat({5'h01, 5'h01, 5'h01, 5'h0E}, 1'b0);
    beat(all4(5'h01), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid, err, cnt} !== 11'd0) begin n_bad++; $display("FAIL arst_ctrl got %b/%b/%b/%0d want 0/0/0/0", in_ready, out_valid, err, cnt); end
    n_cmp++; if (res !== 96'd0) begin n_bad++; $display("FAIL arst_result got %h want 0", res); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_bad++; $display("FAIL arst_release got %b/%b want 1/0", in_ready, out_valid); end
    beat(all4(5'h09), 1'b1);
    n_cmp++; if (res !== {4{24'sd100}}) begin n_bad++; $display("FAIL arst_next got %h want %h", res, {4{24'sd100}}); end
    release_out;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_neg_min;
    test_saturation;
    test_cnt_sat;
    test_hold;
    test_code_err;
    test_clear;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
